// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared MMIO command encoding, register map and SPI bridge state type
package mmio_pkg;

    localparam int         CMD_RD_BIT    = 7;
    localparam logic [6:0] CMD_RSVD_MASK = 7'h7F;

    localparam logic [7:0] MMIO_STATUS = 8'h00;
    localparam logic [7:0] MMIO_CTRL   = 8'h01;
    localparam logic [7:0] MMIO_DATA   = 8'h02;
    localparam logic [7:0] MMIO_IRQ    = 8'h03;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        DRAIN
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-flop synchronizer with rise/fall detect on the synced level
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= {SYNC_STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign sync = chain[SYNC_STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/spi_mmio_bridge.sv
// rtl/spi_mmio_bridge.sv - SPI mode-0 slave issuing single-cycle MMIO reads/writes
// Define SPI_MMIO_BURST_EN for auto-incrementing multi-byte frames.
module spi_mmio_bridge
    import mmio_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sck,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              cs,
    output logic              rd,
    output logic              wr,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata
);

    localparam int CNT_W = $clog2(DATA_W);

    logic sck_sync, sck_rise, sck_fall;
    logic cs_n_sync, cs_n_rise, cs_n_fall;
    logic mosi_sync, mosi_rise, mosi_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck (
        .clk(clk), .rst_n(rst_n), .din(spi_sck),
        .sync(sck_sync), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_n (
        .clk(clk), .rst_n(rst_n), .din(spi_cs_n),
        .sync(cs_n_sync), .rise(cs_n_rise), .fall(cs_n_fall)
    );

    // Same depth as sck so the MOSI level seen at a detected rise is the one the host set up.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi (
        .clk(clk), .rst_n(rst_n), .din(spi_mosi),
        .sync(mosi_sync), .rise(mosi_rise), .fall(mosi_fall)
    );

    logic unused_sync;
    assign unused_sync = &{1'b0, sck_sync, cs_n_rise, mosi_rise, mosi_fall};

    spi_state_t        state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-2:0] rx_sr;
    logic [DATA_W-1:0] tx_sr;
    logic              is_rd;
    logic [DATA_W-1:0] rx_byte;
    logic              byte_done;
`ifdef SPI_MMIO_BURST_EN
    logic              burst_first;
`endif

    assign rx_byte     = {rx_sr, mosi_sync};
    assign byte_done   = sck_rise && (bit_cnt == CNT_W'(DATA_W - 1));
    assign spi_miso_oe = ~cs_n_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            rx_sr    <= '0;
            tx_sr    <= '0;
            is_rd    <= 1'b0;
            cs       <= 1'b0;
            rd       <= 1'b0;
            wr       <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
            spi_miso <= 1'b0;
`ifdef SPI_MMIO_BURST_EN
            burst_first <= 1'b0;
`endif
        end else begin
            cs <= 1'b0;
            rd <= 1'b0;
            wr <= 1'b0;
            if (cs_n_sync) begin
                state    <= IDLE;
                bit_cnt  <= '0;
                spi_miso <= 1'b0;
            end else if (state == IDLE) begin
                if (cs_n_fall) begin
                    state   <= CMD;
                    bit_cnt <= '0;
                end
            end else begin
                if (sck_fall) begin
                    if (state == DATA && is_rd) begin
                        spi_miso <= tx_sr[DATA_W-1];
                        tx_sr    <= {tx_sr[DATA_W-2:0], 1'b0};
                    end else begin
                        spi_miso <= 1'b0;
                    end
                end
                if (sck_rise) begin
                    rx_sr   <= rx_byte[DATA_W-2:0];
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
                if (byte_done) begin
                    bit_cnt <= '0;
                    case (state)
                        CMD: begin
                            is_rd <= rx_byte[CMD_RD_BIT];
                            state <= ((rx_byte[6:0] & CMD_RSVD_MASK) != 7'd0) ? DRAIN : ADDR;
                        end
                        ADDR: begin
                            addr  <= ADDR_W'(rx_byte);
                            state <= DATA;
                            if (is_rd) begin
                                cs <= 1'b1;
                                rd <= 1'b1;
                            end
`ifdef SPI_MMIO_BURST_EN
                            burst_first <= 1'b1;
`endif
                        end
                        DATA: begin
`ifdef SPI_MMIO_BURST_EN
                            // Reads prefetch the next address; writes advance only after the first byte.
                            if (is_rd) begin
                                addr <= addr + ADDR_W'(1);
                                cs   <= 1'b1;
                                rd   <= 1'b1;
                            end else begin
                                if (!burst_first)
                                    addr <= addr + ADDR_W'(1);
                                wdata <= rx_byte;
                                cs    <= 1'b1;
                                wr    <= 1'b1;
                            end
                            burst_first <= 1'b0;
`else
                            if (!is_rd) begin
                                wdata <= rx_byte;
                                cs    <= 1'b1;
                                wr    <= 1'b1;
                            end
                            state <= DRAIN;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            if (rd)
                tx_sr <= rdata;
        end
    end

endmodule

// File: tb/tb_spi_mmio_bridge.sv
// tb/tb_spi_mmio_bridge.sv - randomized scoreboard bench for spi_mmio_bridge
module tb_spi_mmio_bridge;
    import mmio_pkg::*;

    typedef struct packed {
        logic       is_wr;
        logic [7:0] a;
        logic [7:0] d;
    } acc_t;

`ifdef SPI_MMIO_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, spi_sck, spi_cs_n, spi_mosi, spi_miso, spi_miso_oe;
    logic       cs, rd, wr;
    logic [7:0] addr, wdata, rdata;

    logic [7:0] bus_regs [256];
    logic [7:0] ref_regs [256];
    acc_t       exp_q [$];
    int         total = 0;
    int         bad   = 0;
    logic       prev_cs = 1'b0;

    always #5 clk = ~clk;

    assign rdata = bus_regs[addr];

    spi_mmio_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .cs(cs), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata)
    );

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // Register-block model plus bus scoreboard.
    always @(negedge clk) begin
        if (rst_n && (cs || rd || wr)) begin
            total++;
            if (!(cs && (rd ^ wr)) || prev_cs) begin
                bad++;
                $display("FAIL strobe_shape: got cs=%b rd=%b wr=%b prev_cs=%b want one-cycle cs with one of rd/wr",
                         cs, rd, wr, prev_cs);
            end
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_access: got wr=%b addr=%h wdata=%h want none", wr, addr, wdata);
            end else begin
                acc_t e;
                e = exp_q.pop_front();
                if (e.is_wr !== wr || e.a !== addr || (e.is_wr && e.d !== wdata)) begin
                    bad++;
                    $display("FAIL bus_access: got wr=%b addr=%h wdata=%h want wr=%b addr=%h wdata=%h",
                             wr, addr, wdata, e.is_wr, e.a, e.d);
                end
            end
            if (wr)
                bus_regs[addr] = wdata;
        end
        prev_cs = cs;
    end

    task automatic spi_bit(input logic b, output logic m);
        spi_mosi = b;
        repeat (4) @(negedge clk);
        m = spi_miso;
        spi_sck = 1'b1;
        repeat (4) @(negedge clk);
        spi_sck = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check8({tag, "_cs"},   {7'd0, cs},          8'd0);
        check8({tag, "_rd"},   {7'd0, rd},          8'd0);
        check8({tag, "_wr"},   {7'd0, wr},          8'd0);
        check8({tag, "_addr"}, addr,                8'd0);
        check8({tag, "_wdata"}, wdata,              8'd0);
        check8({tag, "_miso"}, {7'd0, spi_miso},    8'd0);
        check8({tag, "_oe"},   {7'd0, spi_miso_oe}, 8'd0);
    endtask

    // Frame-level reference: decides accesses and MISO bytes from the frame bytes alone.
    task automatic run_frame(input logic [7:0] f0, input logic [7:0] f1, input logic [7:0] f2,
                             input logic [7:0] f3, input int nbytes, input int cut);
        logic [7:0] f [4];
        logic [7:0] got [4];
        logic [7:0] expm [4];
        logic [7:0] a;
        logic       m;
        int         nbits, nfull;
        f = '{f0, f1, f2, f3};
        nbits = (cut > 0) ? cut : nbytes * 8;
        nfull = nbits / 8;
        for (int i = 0; i < 4; i++) begin
            got[i]  = 8'h00;
            expm[i] = 8'h00;
        end
        if (f[0][6:0] == 7'd0 && nfull >= 2) begin
            a = f[1];
            if (f[0][7]) begin
                exp_q.push_back('{1'b0, a, 8'h00});
                for (int i = 2; i < nfull; i++) begin
                    if (i == 2 || BURST) begin
                        expm[i] = ref_regs[8'(a + i - 2)];
                        if (BURST)
                            exp_q.push_back('{1'b0, 8'(a + i - 1), 8'h00});
                    end
                end
            end else begin
                for (int i = 2; i < nfull; i++) begin
                    if (i == 2 || BURST) begin
                        exp_q.push_back('{1'b1, 8'(a + i - 2), f[i]});
                        ref_regs[8'(a + i - 2)] = f[i];
                    end
                end
            end
        end
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        check8("miso_oe_active", {7'd0, spi_miso_oe}, 8'd1);
        for (int b = 0; b < nbits; b++) begin
            spi_bit(f[b / 8][7 - (b % 8)], m);
            got[b / 8] = {got[b / 8][6:0], m};
        end
        repeat (4) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (12) @(negedge clk);
        check8("miso_oe_idle", {7'd0, spi_miso_oe}, 8'd0);
        for (int i = 0; i < nfull; i++)
            check8($sformatf("miso_byte%0d_cmd%h_addr%h", i, f[0], f[1]), got[i], expm[i]);
    endtask

    initial begin
        logic [7:0] cmd, a, d0, d1;
        logic       m;
        int         nb, cut;
        for (int i = 0; i < 256; i++) begin
            bus_regs[i] = 8'($urandom);
            ref_regs[i] = bus_regs[i];
        end
        bus_regs[MMIO_STATUS] = 8'hA5;
        ref_regs[MMIO_STATUS] = 8'hA5;
        bus_regs[8'h30] = 8'h64;
        ref_regs[8'h30] = 8'h64;

        rst_n = 1'b0; spi_cs_n = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        run_frame(8'h00, 8'h02, 8'h5A, 8'h00, 3, 0);
        run_frame(8'h80, 8'h30, 8'h00, 8'h00, 3, 0);
        run_frame(8'h00, 8'h50, 8'hC3, 8'h00, 3, 12);
        run_frame(8'h00, 8'h40, 8'h9E, 8'h00, 3, 0);
        run_frame(8'h41, 8'h30, 8'h77, 8'h00, 3, 0);

        // Reset pulse in the middle of the ADDR byte; the frame is abandoned.
        spi_cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int b = 0; b < 12; b++)
            spi_bit((b < 8) ? (b == 0) : (b == 10), m);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_outputs("midframe_reset");
        spi_cs_n = 1'b1;
        repeat (12) @(negedge clk);
        run_frame(8'h80, MMIO_STATUS, 8'h00, 8'h00, 3, 0);

        run_frame(8'h00, 8'hFF, 8'h11, 8'h22, 4, 0);
        run_frame(8'h80, 8'hFF, 8'h00, 8'h00, 4, 0);

        for (int k = 0; k < 24; k++) begin
            cmd = ($urandom_range(0, 1) == 1) ? 8'h80 : 8'h00;
            if ($urandom_range(0, 7) == 0)
                cmd = cmd | 8'($urandom_range(1, 127));
            a   = 8'($urandom);
            d0  = 8'($urandom);
            d1  = 8'($urandom);
            nb  = $urandom_range(3, 4);
            cut = ($urandom_range(0, 5) == 0) ? $urandom_range(1, nb * 8 - 1) : 0;
            run_frame(cmd, a, d0, d1, nb, cut);
        end

        repeat (8) @(negedge clk);
        check8("pending_accesses", 8'(exp_q.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
